// File: rtl/fbcpu_mem_arbiter.sv
// Two-port round-robin arbiter for the shared 64x10 FBCPU RAM, port B bus lock.
// Define FBCPU_ARB_WPROT_EN to block port B writes below PROT_BASE.
module fbcpu_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int PROT_BASE     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_a,
  input  logic                     we_a,
  input  logic [ADDRESS_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0]    wdata_a,
  output logic                     gnt_a,
  output logic                     rvalid_a,
  output logic [DATA_WIDTH-1:0]    rdata_a,
  input  logic                     req_b,
  input  logic                     we_b,
  input  logic [ADDRESS_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0]    wdata_b,
  input  logic                     lock_b,
  output logic                     gnt_b,
  output logic                     rvalid_b,
  output logic [DATA_WIDTH-1:0]    rdata_b,
  output logic                     err_b,
  output logic [ADDRESS_WIDTH-1:0] MAR,
  output logic                     RAMWr,
  output logic [DATA_WIDTH-1:0]    MDRIn,
  input  logic [DATA_WIDTH-1:0]    MDROut
);

  localparam logic [0:0] ST_OPEN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [ADDRESS_WIDTH-1:0] PROT_ADDR =
    ADDRESS_WIDTH'(PROT_BASE);

`ifdef FBCPU_ARB_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  logic [0:0] state_q, state_d;
  logic       last_b_q, last_b_d;
  logic       rvalid_a_q, rvalid_a_d;
  logic       rvalid_b_q, rvalid_b_d;
  logic       err_b_q, err_b_d;
  logic       prot_hit;

  assign prot_hit = WPROT && we_b && (addr_b < PROT_ADDR);

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst) begin
      if (state_q == ST_LOCKED) begin
        gnt_b = req_b;
      end else if (req_a && req_b) begin
        // last_b_q=1 means B won last, so A goes now
        gnt_a = last_b_q;
        gnt_b = !last_b_q;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  always_comb begin
    MAR   = '0;
    RAMWr = 1'b0;
    MDRIn = '0;
    if (gnt_a) begin
      MAR   = addr_a;
      RAMWr = we_a;
      MDRIn = wdata_a;
    end else if (gnt_b) begin
      MAR   = addr_b;
      RAMWr = we_b && !prot_hit;
      MDRIn = wdata_b;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    rvalid_a_d = gnt_a && !we_a;
    rvalid_b_d = gnt_b && !we_b;
    err_b_d    = gnt_b && prot_hit;
    if (gnt_a) last_b_d = 1'b0;
    if (gnt_b) last_b_d = 1'b1;
    if (state_q == ST_OPEN) begin
      if (gnt_b && lock_b) state_d = ST_LOCKED;
    end else begin
      if (!lock_b) state_d = ST_OPEN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_OPEN;
      last_b_q   <= 1'b1;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      err_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_b_q   <= last_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      err_b_q    <= err_b_d;
    end
  end

  // a reset landing on the return cycle discards the read
  assign rvalid_a = rvalid_a_q && rst;
  assign rvalid_b = rvalid_b_q && rst;
  assign rdata_a  = rvalid_a ? MDROut : '0;
  assign rdata_b  = rvalid_b ? MDROut : '0;
  assign err_b    = err_b_q;

endmodule

// File: tb/tb_fbcpu_mem_arbiter.sv
// Directed bench for fbcpu_mem_arbiter with a 1-cycle-latency RAM model.
// Build with +define+FBCPU_ARB_WPROT_EN to exercise write protection.
module tb_fbcpu_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, we_a, gnt_a, rvalid_a;
  logic [5:0] addr_a;
  logic [9:0] wdata_a, rdata_a;
  logic       req_b, we_b, lock_b, gnt_b, rvalid_b, err_b;
  logic [5:0] addr_b;
  logic [9:0] wdata_b, rdata_b;
  logic [5:0] mar;
  logic       ram_wr;
  logic [9:0] mdr_in, mdr_out;

  logic [9:0] mem [64];

  int n_chk = 0;
  int n_ok  = 0;

`ifdef FBCPU_ARB_WPROT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  always #5 clk = ~clk;

  fbcpu_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a),
    .wdata_a(wdata_a), .gnt_a(gnt_a),
    .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b),
    .wdata_b(wdata_b), .lock_b(lock_b), .gnt_b(gnt_b),
    .rvalid_b(rvalid_b), .rdata_b(rdata_b), .err_b(err_b),
    .MAR(mar), .RAMWr(ram_wr), .MDRIn(mdr_in),
    .MDROut(mdr_out)
  );

  always @(posedge clk) begin
    if (ram_wr) mem[mar] <= mdr_in;
    mdr_out <= mem[mar];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
    req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    lock_b = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 10'(i);
    mem[1] = 10'h111;
    mem[2] = 10'h222;
    mem[3] = 10'h033;
    mem[5] = 10'h2A3;
    mdr_out = '0;
    idle();
    rst = 0;
    req_a = 1; req_b = 1; we_b = 1;
    addr_b = 6'd7; wdata_b = 10'h3AA;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("rst_gnt_a", gnt_a, 0);
      chk("rst_gnt_b", gnt_b, 0);
      chk("rst_ramwr", ram_wr, 0);
      chk("rst_err_b", err_b, 0);
    end
    chk("rst_mem7", mem[7], 10'h007);

    // round robin reads: A addr1, B addr2
    rst = 1; we_b = 0; addr_a = 6'd1; addr_b = 6'd2;
    #1;
    chk("rr0_gnt_a", gnt_a, 1);
    chk("rr0_gnt_b", gnt_b, 0);
    chk("rr0_mar", mar, 1);
    tick(); #1;
    chk("rr1_rv_a", rvalid_a, 1);
    chk("rr1_rd_a", rdata_a, 10'h111);
    chk("rr1_rv_b", rvalid_b, 0);
    chk("rr1_gnt_b", gnt_b, 1);
    chk("rr1_gnt_a", gnt_a, 0);
    chk("rr1_mar", mar, 2);
    tick(); #1;
    chk("rr2_rv_b", rvalid_b, 1);
    chk("rr2_rd_b", rdata_b, 10'h222);
    chk("rr2_rv_a", rvalid_a, 0);
    chk("rr2_rd_a", rdata_a, 0);
    chk("rr2_gnt_a", gnt_a, 1);
    tick(); #1;
    chk("rr3_rv_a", rvalid_a, 1);
    chk("rr3_gnt_b", gnt_b, 1);

    // single read A addr5
    tick();
    idle();
    req_a = 1; addr_a = 6'd5;
    #1;
    chk("rr4_rv_b", rvalid_b, 1);
    chk("rr4_rd_b", rdata_b, 10'h222);
    chk("sr_gnt_a", gnt_a, 1);
    chk("sr_mar", mar, 5);
    chk("sr_ramwr", ram_wr, 0);
    tick();
    idle();
    #1;
    chk("sr_rv_a", rvalid_a, 1);
    chk("sr_rd_a", rdata_a, 10'h2A3);
    chk("sr_rv_b", rvalid_b, 0);
    chk("idle_mar", mar, 0);

    // locked burst from B while A keeps requesting
    for (int i = 0; i < 4; i++) begin
      tick();
      req_a = 1; we_a = 0; addr_a = 6'd9;
      req_b = 1; we_b = 1;
      addr_b = 6'(20 + i); wdata_b = 10'(i + 1);
      lock_b = (i < 3);
      #1;
      chk("lk_gnt_a", gnt_a, 0);
      chk("lk_gnt_b", gnt_b, 1);
      chk("lk_ramwr", ram_wr, 1);
      chk("lk_mar", mar, 32'(20 + i));
    end
    tick();
    req_b = 0; we_b = 0; lock_b = 0;
    #1;
    chk("lk_after_gnt_a", gnt_a, 1);
    chk("lk_after_mar", mar, 9);
    for (int i = 0; i < 4; i++)
      chk("lk_mem", mem[20 + i], 32'(i + 1));

    // reset while locked with a read in flight
    tick();
    idle();
    req_b = 1; lock_b = 1; addr_b = 6'd20;
    #1;
    chk("ml_gnt_b", gnt_b, 1);
    tick();
    req_a = 1; addr_a = 6'd1; addr_b = 6'd21;
    rst = 0;
    #1;
    chk("ml_rst_gnt_b", gnt_b, 0);
    chk("ml_rst_rv_b", rvalid_b, 0);
    tick();
    rst = 1;
    #1;
    chk("ml_rv_b", rvalid_b, 0);
    chk("ml_gnt_a", gnt_a, 1);
    chk("ml_gnt_b", gnt_b, 0);
    tick();
    idle();

    // port B writes below and at the protection base
    req_b = 1; we_b = 1; addr_b = 6'd3; wdata_b = 10'h3FF;
    #1;
    chk("wp_gnt_b", gnt_b, 1);
    chk("wp_ramwr", ram_wr, WP ? 0 : 1);
    tick();
    addr_b = 6'd16; wdata_b = 10'h155;
    #1;
    chk("wp_err_b", err_b, WP ? 1 : 0);
    chk("wp16_ramwr", ram_wr, 1);
    tick();
    idle();
    #1;
    chk("wp16_err_b", err_b, 0);
    chk("wp_mem3", mem[3], WP ? 10'h033 : 10'h3FF);
    chk("wp_mem16", mem[16], 10'h155);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
